// File: rtl/input_pre_pkg.sv
// Shared definitions for the input pre-data stage: mode encodings and the
// width of one buffered row (lane data plus the frame-last flag).
package input_pre_pkg;

   localparam logic MODE_SCATTER   = 1'b0;
   localparam logic MODE_BROADCAST = 1'b1;

   function automatic int row_width(input int data_w, input int num_ch);
      return data_w * num_ch + 1;
   endfunction

endpackage

// File: rtl/pe_row_fifo.sv
// Synchronous show-ahead row FIFO with an occupancy count; the head row is
// presented combinationally and reads as zero whenever the FIFO is empty.
module pe_row_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && (count < CW'(DEPTH));
   assign pop_ok  = pop && (count != '0);
   assign rdata   = (count != '0) ? mem[rd_ptr] : '0;

   // Storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/input_pre_data_buffer.sv
// Packs a scalar word stream into NUM_CH-lane rows (scatter or broadcast) and
// buffers the closed rows for the PE array behind a row-wide valid/ready port.
module input_pre_data_buffer
   import input_pre_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       PE_clk,
   input  logic                       PE_rst,
   input  logic                       cfg_mode,
   input  logic [DATA_W-1:0]          din_data,
   input  logic                       din_valid,
   output logic                       din_ready,
   input  logic                       din_last,
   output logic [NUM_CH*DATA_W-1:0]   dout_data,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       dout_last,
   output logic [$clog2(DEPTH+1)-1:0] fill_level
);

   localparam int ROW_W = row_width(DATA_W, NUM_CH);
   localparam int LW    = $clog2(NUM_CH);
   localparam int CW    = $clog2(DEPTH+1);

   logic [LW-1:0]            lane_cnt;
   logic                     mode_q;
   logic [NUM_CH*DATA_W-1:0] asm_q;
   logic [NUM_CH*DATA_W-1:0] row_data;
   logic [ROW_W-1:0]         fifo_rdata;
   logic                     accept;
   logic                     eff_mode;
   logic                     row_close;

   assign din_ready = (fill_level < CW'(DEPTH));
   assign accept    = din_valid && din_ready;

   // A row's mode is fixed by its first word; later words reuse the latch.
   assign eff_mode  = (lane_cnt == '0) ? cfg_mode : mode_q;
   assign row_close = accept && ((eff_mode == MODE_BROADCAST) ||
                                 (lane_cnt == LW'(NUM_CH-1)) || din_last);

   always_comb begin
      row_data = asm_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((eff_mode == MODE_BROADCAST) || (LW'(i) == lane_cnt)) begin
            row_data[i*DATA_W +: DATA_W] = din_data;
         end
      end
   end

   // Clearing the assembly register on close keeps unwritten lanes of a
   // short row at zero.
   always_ff @(posedge PE_clk) begin
      if (PE_rst) begin
         lane_cnt <= '0;
         mode_q   <= MODE_SCATTER;
         asm_q    <= '0;
      end else if (accept) begin
         if (lane_cnt == '0) begin
            mode_q <= cfg_mode;
         end
         if (row_close) begin
            lane_cnt <= '0;
            asm_q    <= '0;
         end else begin
            lane_cnt <= lane_cnt + 1'b1;
            asm_q    <= row_data;
         end
      end
   end

   pe_row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (PE_clk),
      .rst   (PE_rst),
      .push  (row_close),
      .wdata ({din_last, row_data}),
      .pop   (dout_valid && dout_ready),
      .rdata (fifo_rdata),
      .count (fill_level)
   );

   assign dout_valid = (fill_level != '0);
   assign dout_data  = fifo_rdata[NUM_CH*DATA_W-1:0];
   assign dout_last  = fifo_rdata[ROW_W-1];

endmodule

// File: tb/tb_input_pre_data_buffer.sv
// Directed bench for input_pre_data_buffer (DATA_W=8, NUM_CH=4, DEPTH=4):
// a vector table for packing/latency plus sequences for backpressure and reset.
module tb_input_pre_data_buffer;

   logic        PE_clk = 1'b0;
   logic        PE_rst;
   logic        cfg_mode;
   logic [7:0]  din_data;
   logic        din_valid;
   logic        din_ready;
   logic        din_last;
   logic [31:0] dout_data;
   logic        dout_valid;
   logic        dout_ready;
   logic        dout_last;
   logic [2:0]  fill_level;

   int checks   = 0;
   int failures = 0;

   logic [32:0] got [$];

   typedef struct {
      logic        mode;
      logic [7:0]  data;
      logic        last;
      logic        closes;
      logic [31:0] row;
      logic        row_last;
   } vec_t;

   vec_t vec [19];

   input_pre_data_buffer #(
      .DATA_W (8),
      .NUM_CH (4),
      .DEPTH  (4)
   ) dut (
      .PE_clk     (PE_clk),
      .PE_rst     (PE_rst),
      .cfg_mode   (cfg_mode),
      .din_data   (din_data),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_last   (din_last),
      .dout_data  (dout_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .fill_level (fill_level)
   );

   always #5 PE_clk = ~PE_clk;

   // Inputs only change just after a rising edge, so the negedge view of the
   // handshake is what the next rising edge will act on.
   always @(negedge PE_clk) begin
      if (!PE_rst && dout_valid && dout_ready) begin
         got.push_back({dout_last, dout_data});
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic m, input logic [7:0] d, input logic l);
      int  waited;
      bit  taken;
      cfg_mode  = m;
      din_data  = d;
      din_last  = l;
      din_valid = 1'b1;
      waited    = 0;
      taken     = 1'b0;
      while (!taken && waited < 200) begin
         @(negedge PE_clk);
         taken = din_ready;
         @(posedge PE_clk);
         #1;
         waited++;
      end
      din_valid = 1'b0;
      if (!taken) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout word=%0h actual=not_accepted expected=accepted", d);
      end
   endtask

   task automatic waitDrain(input int rows);
      int cyc = 0;
      while ((got.size() < rows || dout_valid) && cyc < 100) begin
         @(negedge PE_clk);
         cyc++;
      end
      if (cyc >= 100) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain_timeout actual=%0d rows expected=%0d rows", got.size(), rows);
      end
   endtask

   task automatic pulseReset();
      PE_rst = 1'b1;
      @(posedge PE_clk);
      #1;
      PE_rst = 1'b0;
   endtask

   initial begin
      vec[0]  = '{1'b0, 8'h01, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[1]  = '{1'b0, 8'h02, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[2]  = '{1'b0, 8'h03, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[3]  = '{1'b0, 8'h04, 1'b0, 1'b1, 32'h04030201, 1'b0};
      vec[4]  = '{1'b0, 8'h0A, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[5]  = '{1'b0, 8'h0B, 1'b1, 1'b1, 32'h00000B0A, 1'b1};
      vec[6]  = '{1'b0, 8'h0C, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[7]  = '{1'b0, 8'h0D, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[8]  = '{1'b0, 8'h0E, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[9]  = '{1'b0, 8'h0F, 1'b0, 1'b1, 32'h0F0E0D0C, 1'b0};
      vec[10] = '{1'b1, 8'h5C, 1'b0, 1'b1, 32'h5C5C5C5C, 1'b0};
      vec[11] = '{1'b1, 8'h11, 1'b0, 1'b1, 32'h11111111, 1'b0};
      vec[12] = '{1'b1, 8'h22, 1'b1, 1'b1, 32'h22222222, 1'b1};
      vec[13] = '{1'b0, 8'h77, 1'b1, 1'b1, 32'h00000077, 1'b1};
      vec[14] = '{1'b0, 8'h01, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[15] = '{1'b0, 8'h02, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[16] = '{1'b1, 8'h03, 1'b0, 1'b0, 32'h0,        1'b0};
      vec[17] = '{1'b1, 8'h04, 1'b0, 1'b1, 32'h04030201, 1'b0};
      vec[18] = '{1'b1, 8'h05, 1'b0, 1'b1, 32'h05050505, 1'b0};

      PE_rst     = 1'b1;
      cfg_mode   = 1'b0;
      din_data   = '0;
      din_valid  = 1'b0;
      din_last   = 1'b0;
      dout_ready = 1'b1;
      repeat (2) @(posedge PE_clk);
      #1;
      PE_rst = 1'b0;

      @(negedge PE_clk);
      checkOutput("rst_dout_valid", dout_valid, 0);
      checkOutput("rst_dout_data",  dout_data,  0);
      checkOutput("rst_dout_last",  dout_last,  0);
      checkOutput("rst_fill_level", fill_level, 0);
      checkOutput("rst_din_ready",  din_ready,  1);
      @(posedge PE_clk);
      #1;

      // Back-to-back words with the PE side always ready: a closed row is
      // visible exactly one cycle after its closing word.
      for (int i = 0; i < 19; i++) begin
         applyStimulus(vec[i].mode, vec[i].data, vec[i].last);
         checkOutput($sformatf("v%0d_valid", i), dout_valid, vec[i].closes);
         if (vec[i].closes) begin
            checkOutput($sformatf("v%0d_data", i), dout_data, vec[i].row);
            checkOutput($sformatf("v%0d_last", i), dout_last, vec[i].row_last);
         end
      end
      repeat (3) @(posedge PE_clk);
      #1;
      checkOutput("table_empty", fill_level, 0);

      // Backpressure: 16 words fill all four slots, then release.
      got.delete();
      dout_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0);
      end
      @(negedge PE_clk);
      checkOutput("bp_din_ready", din_ready,  0);
      checkOutput("bp_fill",      fill_level, 4);
      checkOutput("bp_valid",     dout_valid, 1);
      checkOutput("bp_head",      dout_data,  32'h04030201);
      repeat (2) @(negedge PE_clk);
      checkOutput("bp_hold_data", dout_data, 32'h04030201);
      checkOutput("bp_hold_last", dout_last, 0);
      @(posedge PE_clk);
      #1;
      dout_ready = 1'b1;
      @(negedge PE_clk);
      checkOutput("bp_still_full", din_ready, 0);
      @(negedge PE_clk);
      checkOutput("bp_ready_rise", din_ready, 1);
      checkOutput("bp_fill_3",     fill_level, 3);
      @(posedge PE_clk);
      #1;
      for (int i = 17; i <= 20; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0);
      end
      waitDrain(5);
      checkOutput("bp_row_count", got.size(), 5);
      for (int r = 0; r < 5; r++) begin
         logic [32:0] exp_row;
         exp_row = {1'b0, 8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)};
         if (r < got.size()) begin
            checkOutput($sformatf("bp_row%0d", r), got[r], exp_row);
         end
      end

      // Reset with two buffered rows and a half-built third row.
      got.delete();
      dout_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0);
      end
      @(negedge PE_clk);
      checkOutput("pre_rst_fill", fill_level, 2);
      @(posedge PE_clk);
      #1;
      pulseReset();
      checkOutput("mid_rst_valid", dout_valid, 0);
      checkOutput("mid_rst_fill",  fill_level, 0);
      checkOutput("mid_rst_ready", din_ready,  1);
      checkOutput("mid_rst_data",  dout_data,  0);
      dout_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0);
      end
      waitDrain(1);
      repeat (3) @(negedge PE_clk);
      checkOutput("post_rst_rows", got.size(), 1);
      if (got.size() > 0) begin
         checkOutput("post_rst_row", got[0], {1'b0, 32'h04030201});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
